// File: rtl/tt_arb_pkg.sv
// Shared types and helpers for the io_out pin arbiter.
package tt_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int OWNER_W = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tt_pin_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr upward, modulo N_REQ.
module rr_pick
    import tt_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [OWNER_W-1:0] ptr,
    output logic               any,
    output logic [OWNER_W-1:0] idx
);

    always_comb begin
        logic [OWNER_W-1:0] w_cand;
        w_cand = '0;
        any    = |req;
        idx    = '0;
        // Scan from the farthest candidate back to ptr so the nearest set request wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = OWNER_W'((int'(ptr) + k) % N_REQ);
            if (req[w_cand]) begin
                idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/tt_pin_arbiter.sv
// Round-robin slot scheduler sharing the io_out pin bus among up to four requesters,
// with a one-cycle dead gap between owners and a registered output datapath.
//
// Handshake: a requester holds req[i] high while it wants the bus; gnt[i] is the
// registered answer, and out_valid marks a cycle whose out_data came from a granted,
// still-requesting owner (gnt & req sampled at the previous edge).
module tt_pin_arbiter
    import tt_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int SLOT_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] data,
    output logic [N_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    output logic [OWNER_W-1:0]      out_owner,
    output logic [1:0]              dbg_state
);

    localparam int                   CNT_W    = clog2(SLOT_CYCLES + 1);
    localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [OWNER_W-1:0]   LAST_IDX = OWNER_W'(N_REQ - 1);

    state_t               r_state, w_state_nxt;
    logic [OWNER_W-1:0]   r_owner, w_owner_nxt;
    logic [OWNER_W-1:0]   r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [N_REQ-1:0]     r_gnt, w_gnt_nxt;
    logic [DATA_W-1:0]    r_out_data;
    logic [OWNER_W-1:0]   r_out_owner;
    logic                 r_out_valid;
    logic                 w_any;
    logic [OWNER_W-1:0]   w_idx;
    logic                 w_hit;
    logic [DATA_W-1:0]    w_data [N_REQ];

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req (req),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_data[i] = data[i*DATA_W +: DATA_W];
        end
    end

    assign w_hit = |(r_gnt & req);

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = '0;
        case (r_state)
            GRANT: begin
                if (r_cnt != '0 && req[r_owner]) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = GAP;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                // IDLE and the single GAP cycle both arbitrate at their ending edge.
                w_state_nxt = IDLE;
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_owner_nxt = w_idx;
                    w_cnt_nxt   = CNT_LOAD;
                    w_ptr_nxt   = (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;
                end
            end
        endcase
        if (w_state_nxt == GRANT) begin
            w_gnt_nxt[w_owner_nxt] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_owner <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gnt       <= w_gnt_nxt;
            r_out_valid <= w_hit;
            if (w_hit) begin
                r_out_data  <= w_data[r_owner];
                r_out_owner <= r_owner;
            end
        end
    end

    assign gnt       = r_gnt;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_owner = r_out_owner;
    assign dbg_state = r_state;

endmodule

// File: doc/tt_pin_arbiter.md
# tt_pin_arbiter

Round-robin arbiter and slot scheduler that shares the 8-bit `io_out` pin bus of the user module among up to four internal requesters, such as a counter display, a status register and a debug tap. It grants one requester at a time for a bounded slot, inserts a dead cycle between owners, and registers the selected data onto the output bus. It sits between the functional sub-blocks and the top-level `io_out` assignment. `io_in[0]` feeds the clock, and the reset comes from switch 0.

## Interface
- `N_REQ`, 4, number of requesters (2..4)
- `DATA_W`, 8, data width per requester and of `out_data`
- `SLOT_CYCLES`, 4, maximum grant length in cycles (≥1)
- `clk`  in  1  system clock (`io_in[0]`)
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low (switch 0)
- `req`  in  N_REQ  per-requester request, level-sensitive
- `data`  in  N_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W]
- `gnt`  out  N_REQ  one-hot or zero grant, registered
- `out_data`  out  DATA_W  registered data of current owner, to `io_out`
- `out_valid`  out  1  `out_data` carries granted data this cycle
- `out_owner`  out  2  index of requester whose data is on `out_data`

## Operation
- States: IDLE, GRANT, GAP.
- Round-robin pointer `ptr` (2 b) is reset to 0.
  - Arbitration picks the first set `req[i]` scanning i = ptr, ptr+1, … mod N_REQ.
  - On entering GRANT, `ptr` ← owner+1 mod N_REQ.
- IDLE: `gnt`=0. If any `req` is high at a rising edge, go to GRANT with the picked owner and load slot counter = SLOT_CYCLES−1.
- GRANT: `gnt[owner]`=1.
  - Each edge with counter≠0 and `req[owner]`=1: decrement the counter and stay.
  - Counter==0 or `req[owner]`=0 at an edge: go to GAP.
- GAP: exactly one cycle with `gnt`=0. At its end, arbitrate as in IDLE: go to GRANT if any `req` is high, else go to IDLE.
- Datapath, registered every edge:
  - `out_valid` ← |(`gnt` & `req`).
  - `out_data` ← `data[owner]` when that term is 1, else hold.
  - `out_owner` ← owner when that term is 1, else hold.
- Counter width is clog2(SLOT_CYCLES+1). SLOT_CYCLES=1 gives single-cycle grants. No wrap of the counter past 0.
- Requesters with indices ≥ N_REQ do not exist. `ptr` wraps modulo N_REQ, not modulo 4.

## Timing
- Reset (`rst_n`=0, asynchronous, any time, including mid-grant): state=IDLE, `ptr`=0, `gnt`=0, `out_valid`=0, `out_data`=0, `out_owner`=0, counter=0. The first grant after release follows the normal IDLE rule.
- `req` high sampled at edge E (IDLE) → `gnt` high after E → `out_valid` high after E+1. Request-to-grant latency is 1 cycle; grant-to-output latency is 1 cycle.
- A sustained request holds `gnt` for exactly SLOT_CYCLES cycles, then 1 GAP cycle.
- Early release: a `req[owner]` drop sampled at edge E deasserts `gnt` after E. `out_valid` is already 0 after E because the term is gated by `req`.
- A request arriving during GAP is eligible at the GAP-ending edge. There is no extra idle cycle.
- A single continuous requester gets back-to-back slots separated by one GAP cycle.
- `gnt` is never multi-hot, and it is 0 in IDLE and GAP.

## Structure
- Package `tt_arb_pkg`: state enum (IDLE, GRANT, GAP), `OWNER_W` = 2, and the `clog2` helper for the counter width.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs `req` and `ptr`; outputs `any` and `idx`. It is used at the IDLE and GAP exits.
- Top holds the FSM, counter, `ptr` and output registers.

## Test plan
- Reset: hold `rst_n`=0 for 5 cycles with `req`=4'b1111 → `gnt`=0, `out_valid`=0, `out_data`=0, `out_owner`=0. Assert `rst_n`=0 mid-grant → all outputs are 0 immediately (asynchronous, not on the next edge).
- Single requester, SLOT_CYCLES=4: `req`=4'b0100 held, `data[2]`=8'hA5 → `gnt`=4'b0100 for 4 cycles, 0 for 1 cycle, repeating. `out_valid` pattern is 1111 0 delayed one cycle; `out_data`=8'hA5 and `out_owner`=2 while valid.
- Fairness: `req`=4'b1111 from reset → owners 0,1,2,3,0,1… Each holds 4 cycles, with one GAP between owners. Never two grants at once.
- Early release: owner 1 drops `req` after 2 granted cycles → `gnt[1]` falls the next cycle. `out_valid` shows exactly 2 valid cycles, then GAP, then the next requester.
- GAP arrival: only `req[3]` high, dropped at slot end; `req[0]` rises during the GAP cycle → `gnt`=4'b0001 on the cycle right after GAP, with no IDLE cycle.
- N_REQ=3 and SLOT_CYCLES=1: `req`=3'b111 → grant order 0,1,2,0. Each grant lasts 1 cycle followed by 1 GAP; `ptr` never selects index 3.
